// File: rtl/fu_cdb_buffer_if.sv
// Handshake bundle between a functional unit, the CDB arbiter and branch resolution.
// The buffer connects through the slave modport; its environment uses master.
interface fu_cdb_buffer_if #(
    parameter int PREG_W  = 6,
    parameter int BMASK_W = 4
);
    logic               fu_valid;
    logic [63:0]        fu_result;
    logic [PREG_W-1:0]  fu_tagDest;
    logic [BMASK_W-1:0] fu_bmask;
    logic               fu_stall;

    logic               cdb_req;
    logic [63:0]        cdb_result;
    logic [PREG_W-1:0]  cdb_tag;
    logic [BMASK_W-1:0] cdb_bmask;
    logic               cdb_grant;

    logic               br_valid;
    logic               br_mispredict;
    logic [BMASK_W-1:0] br_bit;

    modport slave (
        input  fu_valid, fu_result, fu_tagDest, fu_bmask,
        output fu_stall,
        output cdb_req, cdb_result, cdb_tag, cdb_bmask,
        input  cdb_grant,
        input  br_valid, br_mispredict, br_bit
    );

    modport master (
        output fu_valid, fu_result, fu_tagDest, fu_bmask,
        input  fu_stall,
        input  cdb_req, cdb_result, cdb_tag, cdb_bmask,
        output cdb_grant,
        output br_valid, br_mispredict, br_bit
    );
endinterface

// File: rtl/fu_cdb_buffer.sv
// In-order result FIFO between one functional unit and the CDB arbiter, with branch-mask tracking.
// Optional macro FUCDB_BYPASS_EN: same-cycle bypass of a new result when no live entry is waiting.
module fu_cdb_buffer #(
    parameter int DEPTH   = 4,
    parameter int PREG_W  = 6,
    parameter int BMASK_W = 4
) (
    input  logic           clock,
    input  logic           reset,
    fu_cdb_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0]        result;
        logic [PREG_W-1:0]  tag;
        logic [BMASK_W-1:0] bmask;
    } entry_t;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];

    logic             full;
    logic             br_correct;
    logic             br_squash;
    logic             head_occupied;
    logic             head_squash;
    logic             fifo_req;
    logic             auto_pop;
    logic             pop;
    logic             in_squash;
    logic             push_ok;
    logic             push_write;
    logic             bypass;
    logic [DEPTH-1:0] squash_vec;
    entry_t           head_e;
    entry_t           in_entry;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign br_correct    = bus.br_valid && !bus.br_mispredict;
    assign br_squash     = bus.br_valid && bus.br_mispredict;
    assign head_e        = entries_q[head_q];
    assign head_occupied = (count_q != '0);
    assign head_squash   = br_squash && |(head_e.bmask & bus.br_bit);

    // A head squashed this cycle must not broadcast; it drains as an auto-pop next cycle.
    assign fifo_req = head_occupied && valid_q[head_q] && !head_squash;
    assign auto_pop = head_occupied && !valid_q[head_q];
    assign pop      = (fifo_req && bus.cdb_grant) || auto_pop;

    assign in_entry.result = bus.fu_result;
    assign in_entry.tag    = bus.fu_tagDest;
    assign in_entry.bmask  = br_correct ? (bus.fu_bmask & ~bus.br_bit) : bus.fu_bmask;
    assign in_squash       = br_squash && |(bus.fu_bmask & bus.br_bit);

    // A full buffer still accepts a result when the head leaves in the same cycle.
    assign push_ok = bus.fu_valid && (!full || pop) && (bus.fu_tagDest != '0) && !in_squash;

    always_comb begin
        squash_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash_vec[i] = br_squash && |(entries_q[i].bmask & bus.br_bit);
        end
    end

`ifdef FUCDB_BYPASS_EN
    logic any_live;

    assign any_live = |(valid_q & ~squash_vec);
    assign bypass   = push_ok && !any_live;
`else
    assign bypass = 1'b0;
`endif

    assign push_write = push_ok && !(bypass && bus.cdb_grant);

    always_comb begin
        // NOTE: every signal written here gets its default first, so no latch can be inferred.
        head_d    = head_q;
        tail_d    = tail_q;
        valid_d   = valid_q & ~squash_vec;
        entries_d = entries_q;

        if (br_correct) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].bmask = entries_q[i].bmask & ~bus.br_bit;
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        // Ordered after pop so a full-buffer push into the departing head slot stays valid.
        if (push_write) begin
            valid_d[tail_q]   = 1'b1;
            entries_d[tail_q] = in_entry;
            tail_d            = tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push_write) - CNT_W'(pop);
    end

    always_comb begin
        bus.cdb_req    = 1'b0;
        bus.cdb_result = '0;
        bus.cdb_tag    = '0;
        bus.cdb_bmask  = '0;
        if (fifo_req) begin
            bus.cdb_req    = 1'b1;
            bus.cdb_result = head_e.result;
            bus.cdb_tag    = head_e.tag;
            bus.cdb_bmask  = br_correct ? (head_e.bmask & ~bus.br_bit) : head_e.bmask;
        end else if (bypass) begin
            bus.cdb_req    = 1'b1;
            bus.cdb_result = in_entry.result;
            bus.cdb_tag    = in_entry.tag;
            bus.cdb_bmask  = in_entry.bmask;
        end
    end

    assign bus.fu_stall = full;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: payload storage is not reset; the valid bits and zeroed outputs gate every read.
    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

    fu_valid_while_full : assert property (
        @(posedge clock) disable iff (!reset) !(bus.fu_valid && full && !pop)
    );

endmodule
